// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- MEM-stage load/store sequencer.
//
// Takes the EX/MEM register outputs and runs a single access on the
// data-memory port using a req/gnt/rvalid handshake. stall_o holds EX/MEM
// and all earlier stages until the access completes. The block builds byte
// enables and lane-aligned write data for stores. For loads it shifts the
// returned doubleword down to the addressed bytes and sign- or zero-extends
// the result.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   lsu_op_i              operation from EX/MEM (LSU_NONE = no access)
//   mem_write_i           1 for store ops
//   addr_i                byte address
//   store_data_i          store operand, LSB-justified
//   stall_o               freeze EX/MEM and earlier stages
//   load_data_o           extended load result, valid with load_valid_o
//   load_valid_o          one-cycle load completion pulse
//   misaligned_o          access not naturally aligned, no request issued
//   bus_err_o             one-cycle pulse on response timeout
//   dmem_req_o/we_o/addr_o/be_o/wdata_o   memory request channel
//   dmem_gnt_i            request accepted this cycle
//   dmem_rvalid_i         read data valid
//   dmem_rdata_i          read data, doubleword lanes

package lsu_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LD   = 4'd4,
        LSU_LBU  = 4'd5,
        LSU_LHU  = 4'd6,
        LSU_LWU  = 4'd7,
        LSU_SB   = 4'd8,
        LSU_SH   = 4'd9,
        LSU_SW   = 4'd10,
        LSU_SD   = 4'd11
    } lsu_op_t;

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(input lsu_op_t op);
        logic [1:0] size;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: size = 2'd0;
            LSU_LH, LSU_LHU, LSU_SH: size = 2'd1;
            LSU_LW, LSU_LWU, LSU_SW: size = 2'd2;
            default:                 size = 2'd3;
        endcase
        return size;
    endfunction

    function automatic logic is_load(input lsu_op_t op);
        return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LD,
                          LSU_LBU, LSU_LHU, LSU_LWU};
    endfunction

endpackage

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  lsu_op_t       lsu_op_i,
    input  logic          mem_write_i,
    input  logic [63:0]   addr_i,
    input  logic [63:0]   store_data_i,
    output logic          stall_o,
    output logic [63:0]   load_data_o,
    output logic          load_valid_o,
    output logic          misaligned_o,
    output logic          bus_err_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [63:0]   dmem_addr_o,
    output logic [7:0]    dmem_be_o,
    output logic [63:0]   dmem_wdata_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [63:0]   dmem_rdata_i
);

    typedef enum logic [1:0] {IDLE, WAIT_G, WAIT_R, DONE} state_t;

    // The counter only needs to reach RESP_TIMEOUT-1. The last WAIT_R
    // cycle before the timeout is the one where the count equals that value.
    localparam int            CW       = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    lsu_op_t       lat_op;
    logic          lat_we;
    logic [63:0]   lat_addr;
    logic [7:0]    lat_be;
    logic [63:0]   lat_wdata;
    logic [63:0]   load_data_q;

    // Decode of the incoming EX/MEM request
    logic [2:0]  in_off;
    logic [2:0]  in_off_mask;
    logic [7:0]  in_size_be;
    logic        in_valid;
    logic        in_aligned;
    logic        in_issue;
    logic [7:0]  in_be;
    logic [63:0] in_wdata;

    // NOTE: every signal written in an always_comb gets a default first,
    // so no path through the block can leave a value unassigned and infer
    // a latch.
    always_comb begin
        in_off      = addr_i[2:0];
        in_size_be  = 8'h01;
        in_off_mask = 3'd0;
        case (op_size(lsu_op_i))
            2'd0:    begin in_size_be = 8'h01; in_off_mask = 3'd0; end
            2'd1:    begin in_size_be = 8'h03; in_off_mask = 3'd1; end
            2'd2:    begin in_size_be = 8'h0F; in_off_mask = 3'd3; end
            default: begin in_size_be = 8'hFF; in_off_mask = 3'd7; end
        endcase
        in_valid   = (lsu_op_i != LSU_NONE);
        in_aligned = ((in_off & in_off_mask) == 3'd0);
        in_issue   = in_valid && in_aligned;
        in_be      = in_size_be << in_off;
        in_wdata   = store_data_i << {in_off, 3'b000};
    end

    // Select the addressed bytes from the returned doubleword and extend them
    function automatic logic [63:0] extend_load(input lsu_op_t op,
                                                input logic [63:0] raw);
        logic [63:0] res;
        case (op)
            LSU_LB:  res = {{56{raw[7]}},  raw[7:0]};
            LSU_LBU: res = {56'd0,         raw[7:0]};
            LSU_LH:  res = {{48{raw[15]}}, raw[15:0]};
            LSU_LHU: res = {48'd0,         raw[15:0]};
            LSU_LW:  res = {{32{raw[31]}}, raw[31:0]};
            LSU_LWU: res = {32'd0,         raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // NOTE: all state updates in the always_ff use non-blocking assignments,
    // so every register samples the values from before the edge.
    always_ff @(posedge clk) begin
        // NOTE: reset clears every register here. The block has no storage
        // arrays, so nothing is left out of reset.
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_op      <= LSU_NONE;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_be      <= '0;
            lat_wdata   <= '0;
            load_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (in_issue) begin
                        lat_op    <= lsu_op_i;
                        lat_we    <= mem_write_i;
                        lat_addr  <= addr_i;
                        lat_be    <= in_be;
                        lat_wdata <= in_wdata;
                        if (!dmem_gnt_i)
                            state <= WAIT_G;
                        else if (is_load(lsu_op_i))
                            state <= WAIT_R;
                        else
                            state <= DONE;
                    end
                end
                WAIT_G: begin
                    cnt <= '0;
                    if (dmem_gnt_i)
                        state <= is_load(lat_op) ? WAIT_R : DONE;
                end
                WAIT_R: begin
                    // rvalid takes priority over a timeout in the same cycle
                    if (dmem_rvalid_i) begin
                        load_data_q <= extend_load(lat_op,
                                           dmem_rdata_i >> {lat_addr[2:0], 3'b000});
                        cnt         <= '0;
                        state       <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        load_data_q <= '0;
                        cnt         <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // EX/MEM still holds the finished op this cycle, so the
                    // inputs are not looked at here. Otherwise the op would
                    // be issued a second time.
                    load_data_q <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode. During reset everything is held at zero.
    always_comb begin
        stall_o      = 1'b0;
        load_valid_o = 1'b0;
        misaligned_o = 1'b0;
        bus_err_o    = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = '0;
        dmem_wdata_o = '0;
        load_data_o  = rst ? '0 : load_data_q;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (in_valid && !in_aligned) begin
                        misaligned_o = 1'b1;
                    end else if (in_issue) begin
                        stall_o      = 1'b1;
                        dmem_req_o   = 1'b1;
                        dmem_we_o    = mem_write_i;
                        dmem_addr_o  = {addr_i[63:3], 3'b000};
                        dmem_be_o    = in_be;
                        dmem_wdata_o = in_wdata;
                    end
                end
                WAIT_G: begin
                    stall_o      = 1'b1;
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = lat_we;
                    dmem_addr_o  = {lat_addr[63:3], 3'b000};
                    dmem_be_o    = lat_be;
                    dmem_wdata_o = lat_wdata;
                end
                WAIT_R: begin
                    stall_o   = 1'b1;
                    bus_err_o = !dmem_rvalid_i && (cnt == CNT_LAST);
                end
                DONE: begin
                    load_valid_o = is_load(lat_op);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- directed testbench for lsu_ctrl.
// Expected load results go into a scoreboard queue when each load is driven.
// They are popped and compared when the DUT raises load_valid_o.
// RESP_TIMEOUT is set to 4 so the timeout path can be reached in a few cycles.

module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    lsu_op_t     lsu_op_i;
    logic        mem_write_i;
    logic [63:0] addr_i;
    logic [63:0] store_data_i;
    logic        stall_o;
    logic [63:0] load_data_o;
    logic        load_valid_o;
    logic        misaligned_o;
    logic        bus_err_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [7:0]  dmem_be_o;
    logic [63:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;

    always #5 clk = ~clk;

    lsu_ctrl #(.RESP_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_op_i     (lsu_op_i),
        .mem_write_i  (mem_write_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"},   stall_o,      1'b0);
        check({tag, "_req"},     dmem_req_o,   1'b0);
        check({tag, "_we"},      dmem_we_o,    1'b0);
        check({tag, "_addr"},    dmem_addr_o,  64'h0);
        check({tag, "_be"},      dmem_be_o,    8'h0);
        check({tag, "_wdata"},   dmem_wdata_o, 64'h0);
        check({tag, "_lvalid"},  load_valid_o, 1'b0);
        check({tag, "_ldata"},   load_data_o,  64'h0);
        check({tag, "_misal"},   misaligned_o, 1'b0);
        check({tag, "_buserr"},  bus_err_o,    1'b0);
    endtask

    // One aligned access. Called and returns at posedge+1.
    // gnt is driven in cycle gnt_dly and rvalid in cycle gnt_dly+rv_dly
    // (rv_dly < 0: never). Cycle 0 is the cycle the op is presented.
    task automatic do_access(input string tag, input lsu_op_t op,
                             input logic [63:0] addr, input logic [63:0] sdata,
                             input int gnt_dly, input int rv_dly,
                             input logic [63:0] rdata,
                             input logic [63:0] exp_addr, input logic [7:0] exp_be,
                             input logic [63:0] exp_wdata, input int exp_stall,
                             input logic [63:0] exp_load, input logic exp_err);
        logic ld;
        int   stalls;
        int   errs;
        logic done;
        exp_t e;
        ld = op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU};
        if (ld) sb_q.push_back('{data: exp_load, err: exp_err});
        lsu_op_i     = op;
        mem_write_i  = !ld;
        addr_i       = addr;
        store_data_i = sdata;
        stalls = 0;
        errs   = 0;
        done   = 1'b0;
        for (int c = 0; c < 64; c++) begin
            dmem_gnt_i    = (c == gnt_dly);
            dmem_rvalid_i = (rv_dly >= 0) && (c == gnt_dly + rv_dly);
            dmem_rdata_i  = dmem_rvalid_i ? rdata : 64'h5A5A_A5A5_5A5A_A5A5;
            @(negedge clk);
            if (c == 0 || c == gnt_dly) begin
                check({tag, "_req"},   dmem_req_o,   1'b1);
                check({tag, "_we"},    dmem_we_o,    !ld);
                check({tag, "_addr"},  dmem_addr_o,  exp_addr);
                check({tag, "_be"},    dmem_be_o,    exp_be);
                check({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
            end
            if (c > 0 && !stall_o) begin
                done = 1'b1;
                check({tag, "_done_lvalid"}, load_valid_o, ld);
                check({tag, "_done_req"},    dmem_req_o,   1'b0);
                check({tag, "_done_buserr"}, bus_err_o,    1'b0);
                if (load_valid_o) begin
                    check({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1'b1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check({tag, "_ldata"},  load_data_o, e.data);
                        check({tag, "_errcnt"}, errs,        e.err ? 1 : 0);
                    end
                end else begin
                    check({tag, "_ldata_zero"}, load_data_o, 64'h0);
                    check({tag, "_errcnt"},     errs,        0);
                end
            end else begin
                if (stall_o)   stalls++;
                if (bus_err_o) errs++;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        check({tag, "_completed"}, done,   1'b1);
        check({tag, "_stalls"},    stalls, exp_stall);
        lsu_op_i      = LSU_NONE;
        mem_write_i   = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        lsu_op_i      = LSU_NONE;
        mem_write_i   = 1'b0;
        addr_i        = 64'h0;
        store_data_i  = 64'h0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 64'h0;

        // Reset for two cycles, then idle
        @(negedge clk);
        check_quiet("rst1");
        @(posedge clk); #1;
        @(negedge clk);
        check_quiet("rst2");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle");
        @(posedge clk); #1;

        // Stray gnt and rvalid while idle are ignored
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check_quiet("stray");
        @(posedge clk); #1;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check_quiet("stray_after");
        @(posedge clk); #1;

        // Stores
        do_access("sb", LSU_SB, 64'h1003, 64'hAB, 0, -1, 64'h0,
                  64'h1000, 8'h08, 64'hAB00_0000, 1, 64'h0, 1'b0);
        do_access("sh", LSU_SH, 64'h7002, 64'hCAFE, 1, -1, 64'h0,
                  64'h7000, 8'h0C, 64'hCAFE_0000, 2, 64'h0, 1'b0);
        do_access("sw", LSU_SW, 64'h7004, 64'hDEAD_BEEF, 0, -1, 64'h0,
                  64'h7000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1, 64'h0, 1'b0);
        do_access("sd", LSU_SD, 64'h5008, 64'h1122_3344_5566_7788, 1, -1, 64'h0,
                  64'h5008, 8'hFF, 64'h1122_3344_5566_7788, 2, 64'h0, 1'b0);

        // Loads
        do_access("lh", LSU_LH, 64'h2006, 64'h0, 2, 3, 64'h8001_0000_0000_0000,
                  64'h2000, 8'hC0, 64'h0, 6, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        do_access("lwu", LSU_LWU, 64'h2004, 64'h0, 0, 1, 64'hF000_0000_1234_5678,
                  64'h2000, 8'hF0, 64'h0, 2, 64'h0000_0000_F000_0000, 1'b0);
        do_access("lb", LSU_LB, 64'h6005, 64'h0, 0, 2, 64'h0000_8500_0000_0000,
                  64'h6000, 8'h20, 64'h0, 3, 64'hFFFF_FFFF_FFFF_FF85, 1'b0);
        do_access("lbu", LSU_LBU, 64'h6005, 64'h0, 1, 1, 64'h0000_8500_0000_0000,
                  64'h6000, 8'h20, 64'h0, 3, 64'h0000_0000_0000_0085, 1'b0);
        do_access("lw", LSU_LW, 64'h8000, 64'h0, 0, 1, 64'h1234_5678_8765_4321,
                  64'h8000, 8'h0F, 64'h0, 2, 64'hFFFF_FFFF_8765_4321, 1'b0);
        do_access("lhu", LSU_LHU, 64'h8002, 64'h0, 0, 1, 64'h0000_0000_9ABC_0000,
                  64'h8000, 8'h0C, 64'h0, 2, 64'h0000_0000_0000_9ABC, 1'b0);
        do_access("ld", LSU_LD, 64'h8008, 64'h0, 0, 1, 64'h0123_4567_89AB_CDEF,
                  64'h8008, 8'hFF, 64'h0, 2, 64'h0123_4567_89AB_CDEF, 1'b0);

        // Misaligned: flagged combinationally, no request, no state change
        lsu_op_i = LSU_LD;
        addr_i   = 64'h3004;
        @(negedge clk);
        check("misal_flag",  misaligned_o, 1'b1);
        check("misal_req",   dmem_req_o,   1'b0);
        check("misal_stall", stall_o,      1'b0);
        @(posedge clk); #1;
        lsu_op_i = LSU_SH;
        addr_i   = 64'h1001;
        mem_write_i = 1'b1;
        @(negedge clk);
        check("misal_sh_flag", misaligned_o, 1'b1);
        check("misal_sh_req",  dmem_req_o,   1'b0);
        @(posedge clk); #1;
        lsu_op_i    = LSU_NONE;
        mem_write_i = 1'b0;
        @(negedge clk);
        check_quiet("misal_after");
        @(posedge clk); #1;

        // Timeout: four WAIT_R cycles without rvalid, error in the fourth
        do_access("to", LSU_LD, 64'h3000, 64'h0, 0, -1, 64'h0,
                  64'h3000, 8'hFF, 64'h0, 1 + TO, 64'h0, 1'b1);
        // Late rvalid after the timed-out access is ignored
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'hFEED_FACE_FEED_FACE;
        @(negedge clk);
        check_quiet("late_rv");
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check_quiet("late_rv_after");
        @(posedge clk); #1;

        // rvalid in the cycle the timeout would fire: rvalid wins
        do_access("rv_edge", LSU_LD, 64'h3008, 64'h0, 0, TO, 64'hCAFE_F00D_0BAD_BEEF,
                  64'h3008, 8'hFF, 64'h0, 1 + TO, 64'hCAFE_F00D_0BAD_BEEF, 1'b0);

        // Reset during WAIT_R, rvalid the cycle after
        lsu_op_i    = LSU_LW;
        mem_write_i = 1'b0;
        addr_i      = 64'h4000;
        dmem_gnt_i  = 1'b1;
        @(negedge clk);
        check("mid_req", dmem_req_o, 1'b1);
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check_quiet("mid_rst");
        @(posedge clk); #1;
        rst           = 1'b0;
        lsu_op_i      = LSU_NONE;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'h1111_2222_3333_4444;
        @(negedge clk);
        check_quiet("mid_late_rv");
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check_quiet("mid_after");
        @(posedge clk); #1;

        // A normal access still works after the mid-transaction reset
        do_access("post_rst", LSU_LB, 64'h4001, 64'h0, 0, 1, 64'h0000_0000_0000_7F00,
                  64'h4000, 8'h02, 64'h0, 2, 64'h0000_0000_0000_007F, 1'b0);

        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer for the MEM stage. Consumes the EX/MEM register outputs (lsu_op, mem_write, alu_result as address, store_data).
- Runs a req/gnt/rvalid handshake on the single data-memory port and asserts stall_o to freeze the EX/MEM register and all earlier stages until the access completes.
- Generates byte enables, aligns write data, and aligns plus sign- or zero-extends load data for the MEM/WB register.

Parameters:
- RESP_TIMEOUT, 255, max cycles in WAIT_R without dmem_rvalid_i before a bus error; must be ≥1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- lsu_op_i  input  lsu_op_t  from EX/MEM; LSU_NONE = no access; loads LB/LH/LW/LD/LBU/LHU/LWU; stores SB/SH/SW/SD
- mem_write_i  input  1  from EX/MEM; 1 for store ops
- addr_i  input  64  byte address (EX/MEM alu_result)
- store_data_i  input  64  store operand, LSB-justified
- stall_o  output  1  hold EX/MEM and earlier stages
- load_data_o  output  64  extended load result, valid while load_valid_o=1
- load_valid_o  output  1  one-cycle completion pulse for a load
- misaligned_o  output  1  access not naturally aligned; no bus request issued
- bus_err_o  output  1  one-cycle pulse on response timeout
- dmem_req_o  output  1  memory request
- dmem_we_o  output  1  1 = write
- dmem_addr_o  output  64  addr with [2:0] forced to 0
- dmem_be_o  output  8  byte enables
- dmem_wdata_o  output  64  lane-aligned write data
- dmem_gnt_i  input  1  request accepted this cycle
- dmem_rvalid_i  input  1  read data valid
- dmem_rdata_i  input  64  read data, doubleword lanes

Behaviour:
- Clocking and reset: single clock domain, synchronous active-high reset.
  - Reset: state=IDLE; timeout counter=0; latched addr/be/wdata/op=0; load_data_o=0.
  - All outputs 0 during and after reset until a new op arrives.
- Access size: B=1, H=2, W=4, D=8 bytes. off=addr[2:0].
  - Misaligned if off is not a multiple of size.
  - be = ((1<<size)-1) << off.
  - wdata = store_data_i << (8*off).
- IDLE:
  - lsu_op_i==LSU_NONE: all outputs 0.
  - Misaligned op: misaligned_o=1 combinationally, stall_o=0, no request, no state change.
  - Aligned op: dmem_req_o=1 with addr/be/wdata/we driven combinationally from inputs; stall_o=1; inputs latched.
  - If dmem_gnt_i in the same cycle: store → DONE, load → WAIT_R. Otherwise → WAIT_G.
- WAIT_G:
  - req held with latched values; stall_o=1.
  - On gnt: store → DONE, load → WAIT_R.
  - No timeout in this state.
- WAIT_R:
  - req=0; stall_o=1; counter increments each cycle.
  - On dmem_rvalid_i: register load_data_o = extend(rdata >> 8*off_latched) per op (LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD none); → DONE; counter cleared.
  - If counter reaches RESP_TIMEOUT with no rvalid: bus_err_o=1 that cycle; load_data_o=0; → DONE.
- DONE (exactly one cycle):
  - stall_o=0; load_valid_o=1 if the latched op is a load; → IDLE.
  - Inputs are ignored in this cycle, because EX/MEM still holds the finished op. This prevents re-issue.
- Latency:
  - Store, gnt in cycle 0: 1 stall cycle.
  - Load, gnt in cycle 0 and rvalid in cycle 1: 2 stall cycles, data in cycle 2.
- Stray handshakes: dmem_rvalid_i outside WAIT_R is ignored; dmem_gnt_i while req=0 is ignored.
- rvalid and timeout in the same cycle: rvalid wins, bus_err_o=0.
- Reset mid-transaction: back to IDLE next edge; req drops. A late rvalid after reset is ignored.
- Inputs must stay stable while stall_o=1 (guaranteed by the pipeline). The block relies only on latched copies after IDLE.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, lsu_op_i=LSU_NONE → all outputs 0; state stays IDLE.
- SB, addr=0x1003, store_data=0xAB, gnt same cycle → dmem_addr=0x1000, be=0x08, wdata=0xAB000000, we=1; stall high 1 cycle; DONE next cycle.
- LH, addr=0x2006, gnt after 2 cycles, rvalid 3 cycles later, rdata=0x8001_0000_0000_0000:
  - be=0xC0; stall_o high for 6 cycles.
  - load_data_o=0xFFFF_FFFF_FFFF_8001 with load_valid_o=1 in the DONE cycle.
  - The same inputs are not re-issued in that cycle.
- LWU, addr=0x2004, rdata=0xF000_0000_1234_5678 → load_data_o=0x0000_0000_F000_0000.
- LD, addr=0x3004 → misaligned_o=1; dmem_req_o=0; stall_o=0.
- LD, RESP_TIMEOUT=4, no rvalid → bus_err_o pulses after 4 WAIT_R cycles, load_data_o=0; rvalid arriving later is ignored.
- Reset mid-transaction: rst asserted in WAIT_R, rvalid next cycle → stays IDLE; load_valid_o=0.
